serial_adder_fsm: RTL and testbench

- Bit-serial counterpart of the team's parallel N-bit adder (scalable_size_adder).
- Accepts two N-bit operands and a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, with a single carry flip-flop and the majority function for carry generation.
- Returns the registered N-bit sum and carry-out over a second valid/ready handshake.
- Used where area matters more than latency, and as a cross-check against the parallel adder in mixed datapaths.

---
 rtl/serial_adder_fsm.sv | 79 +++++++
 tb/tb_serial_adder_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial N-bit adder, LSB-first, one bit per clock, with valid/ready on input and result
// Ports: clk; rst_n (async, active-low); in_valid/in_ready handshake for operands a, b, c_in;
//        res_valid/res_ready handshake for the registered sum and c_out; busy is high while not idle.
// Define SERIAL_ADDER_OVF_EN to add the ovf output (signed overflow of a + b + c_in), which is loaded together with sum.
module serial_adder_fsm #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic [N-1:0] a_sr, b_sr, acc, acc_n;
  logic [CW-1:0] cnt;
  logic carry, s, maj, last;
  assign s = a_sr[0] ^ b_sr[0] ^ carry;
  assign maj = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] | b_sr[0]));
  // The new bit enters at the MSB; the shift form stays legal when N = 1.
  assign acc_n = (acc >> 1) | (N'(s) << (N - 1));
  assign last = cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    in_ready = state == IDLE;
    res_valid = state == HOLD;
    busy = state != IDLE;
    state_n = (state == IDLE && in_valid) ? SHIFT :
              (state == SHIFT && last) ? HOLD :
              (state == HOLD && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      acc <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_sr <= a;
      b_sr <= b;
      carry <= c_in;
      acc <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      carry <= maj;
      acc <= acc_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= acc_n;
        c_out <= maj;
`ifdef SERIAL_ADDER_OVF_EN
        // On the final edge, carry holds the carry into the MSB and maj is the carry out of it.
        ovf <= carry ^ maj;
`endif
      end
    end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: directed and random checks of serial_adder_fsm against an arithmetic reference
module tb_serial_adder_fsm;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n, in_valid, res_ready, c_in, in_ready, res_valid, c_out, busy;
  logic [N-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int passed = 0;
  serial_adder_fsm #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c_in(c_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .sum(sum),
    .c_out(c_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'd0);
    chk({tag, "_c_out"}, 64'(c_out), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
  endtask
  // Called at a negedge with the block idle; offers ra/rb/rc, follows the operation to completion,
  // holds the result for `hold` cycles while offering na/nb/nc, then releases it.
  task automatic run(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rc, input int hold,
                     input logic [N-1:0] na, input logic [N-1:0] nb, input logic nc);
    int e, sa, sb, r;
    logic [N-1:0] es;
    logic ec, eo;
    e = int'(ra) + int'(rb) + int'(rc);
    es = N'(e);
    ec = e[N];
    sa = int'(ra) >= (1 << (N - 1)) ? int'(ra) - (1 << N) : int'(ra);
    sb = int'(rb) >= (1 << (N - 1)) ? int'(rb) - (1 << N) : int'(rb);
    r = sa + sb + int'(rc);
    eo = r > (1 << (N - 1)) - 1 || r < -(1 << (N - 1));
    a = ra;
    b = rb;
    c_in = rc;
    in_valid = 1'b1;
    res_ready = hold == 0;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("busy_shift", 64'(busy), 64'd1);
      chk("res_valid_early", 64'(res_valid), 64'd0);
      chk("in_ready_shift", 64'(in_ready), 64'd0);
      in_valid = 1'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      c_in = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("sum", 64'(sum), 64'(es));
    chk("c_out", 64'(c_out), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 64'(ovf), 64'(eo));
`endif
    chk("busy_hold", 64'(busy), 64'd1);
    chk("in_ready_hold", 64'(in_ready), 64'd0);
    if (hold > 0) begin
      a = na;
      b = nb;
      c_in = nc;
      in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        chk("bp_sum", 64'(sum), 64'(es));
        chk("bp_c_out", 64'(c_out), 64'(ec));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      res_ready = 1'b1;
    end
    @(negedge clk);
    chk("released_res_valid", 64'(res_valid), 64'd0);
    chk("released_busy", 64'(busy), 64'd0);
    chk("released_in_ready", 64'(in_ready), 64'd1);
    chk("retained_sum", 64'(sum), 64'(es));
    chk("retained_c_out", 64'(c_out), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk("retained_ovf", 64'(ovf), 64'(eo));
`endif
  endtask
  initial begin
    logic [N-1:0] na, nb;
    logic nc;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 3'd3;
    b = 3'd5;
    c_in = 1'b0;
    res_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset("rst");
    end
    rst_n = 1'b1;
    run(3'b011, 3'b101, 1'b0, 0, '0, '0, 1'b0);
    run(3'd7, 3'd7, 1'b1, 0, '0, '0, 1'b0);
    run(3'd3, 3'd1, 1'b0, 0, '0, '0, 1'b0);
    a = 3'd5;
    b = 3'd6;
    c_in = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    chk_reset("mid_rst_held");
    rst_n = 1'b1;
    run(3'd2, 3'd2, 1'b1, 0, '0, '0, 1'b0);
    run(3'd6, 3'd5, 1'b1, 5, 3'd4, 3'd7, 1'b0);
    run(3'd4, 3'd7, 1'b0, 0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      na = N'($urandom);
      nb = N'($urandom);
      nc = 1'($urandom);
      run(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)), na, nb, nc);
      if (k % 3 == 0) run(na, nb, nc, 0, '0, '0, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
